// File: rtl/compute_clock_pkg.sv
// Shared types and constants for the compute clock-gate sequencer.
// Latency: n/a (types, constants and one width helper only).
// Backpressure: n/a.
package compute_clock_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_RUN       = 3'd2,
    S_STALL     = 3'd3,
    S_SETTLE    = 3'd4
  } state_e;

  localparam logic [1:0] EXIT_BUDGET = 2'd0;
  localparam logic [1:0] EXIT_STOP   = 2'd1;
  localparam logic [1:0] EXIT_LOCK   = 2'd2;

  // Width of the settle counter. A zero delay never uses the counter,
  // but the vector still needs at least one bit to be legal.
  function automatic int resume_cnt_w(input int resume_delay);
    int w;
    w = $clog2(resume_delay + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sync_bit_2ff.sv
// Two-flop synchronizer for a single level signal; resets to 0.
// Latency: 2 clk cycles from a stable input to q.
// Backpressure: none (free-running level path).
// Ports: clk, rst_n (async active-low), d (async input), q (synchronized).
module sync_bit_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/compute_clock_gate_ctrl.sv
// Sequences the compute clock enable: budgeted/unbounded runs, stall freeze, settle resume.
// Latency: enable is a flop; decisions at edge k show on compute_clock_en in cycle k+1.
// Backpressure: stall_req levels freeze the enable; stall_ack confirms the freeze per requester.
// Ports: control_clock/sync_rst_n; locked (async); start/cycle_budget/stop run control;
//        stall_req/stall_ack handshake; compute_clock_en, running, done, exit_reason, cycle_count status.
module compute_clock_gate_ctrl
  import compute_clock_pkg::*;
#(
  parameter int N_REQ        = 4,
  parameter int COUNT_W      = 48,
  parameter int RESUME_DELAY = 2
) (
  input  logic               control_clock,
  input  logic               sync_rst_n,
  input  logic               locked,
  input  logic               start,
  input  logic [COUNT_W-1:0] cycle_budget,
  input  logic               stop,
  input  logic [N_REQ-1:0]   stall_req,
  output logic [N_REQ-1:0]   stall_ack,
  output logic               compute_clock_en,
  output logic               running,
  output logic               done,
  output logic [1:0]         exit_reason,
  output logic [COUNT_W-1:0] cycle_count
);

  localparam int RCW = resume_cnt_w(RESUME_DELAY);
  localparam logic [RCW-1:0] SETTLE_LAST = RCW'((RESUME_DELAY > 0) ? (RESUME_DELAY - 1) : 0);

  logic locked_s;

  sync_bit_2ff u_lock_sync (
    .clk   (control_clock),
    .rst_n (sync_rst_n),
    .d     (locked),
    .q     (locked_s)
  );

  state_e             state_q,   state_d;
  logic [COUNT_W-1:0] budget_q,  budget_d;
  logic [COUNT_W-1:0] count_q,   count_d;
  logic               en_q,      en_d;
  logic [N_REQ-1:0]   ack_q,     ack_d;
  logic               running_q, running_d;
  logic               done_q,    done_d;
  logic [1:0]         exit_q,    exit_d;
  logic [RCW-1:0]     settle_q,  settle_d;

  logic       any_req;
  logic       last_cycle;
  logic       end_run;
  logic [1:0] end_reason;

  always_comb begin
    state_d    = state_q;
    budget_d   = budget_q;
    running_d  = running_q;
    exit_d     = exit_q;
    settle_d   = settle_q;
    done_d     = 1'b0;
    end_run    = 1'b0;
    end_reason = EXIT_BUDGET;
    any_req    = |stall_req;

    // Count every enabled cycle; saturation only matters for unbounded runs.
    count_d = (en_q && (count_q != '1)) ? (count_q + COUNT_W'(1)) : count_q;

    // The current cycle is the final budgeted edge.
    last_cycle = en_q && (budget_q != '0) && ((count_q + COUNT_W'(1)) == budget_q);

    case (state_q)
      S_IDLE: begin
        // start beats a simultaneous stop; stop alone is meaningless here.
        if (start) begin
          budget_d  = cycle_budget;
          count_d   = '0;
          running_d = 1'b1;
          state_d   = S_WAIT_LOCK;
        end
      end
      S_WAIT_LOCK: begin
        if (stop) begin
          end_run    = 1'b1;
          end_reason = EXIT_STOP;
        end else if (locked_s) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (!locked_s) begin
          end_run    = 1'b1;
          end_reason = EXIT_LOCK;
        end else if (stop) begin
          end_run    = 1'b1;
          end_reason = EXIT_STOP;
        end else if (last_cycle) begin
          // Exhaustion outranks a stall landing on the same edge.
          end_run    = 1'b1;
          end_reason = EXIT_BUDGET;
        end else if (any_req) begin
          state_d = S_STALL;
        end
      end
      S_STALL: begin
        if (!locked_s) begin
          end_run    = 1'b1;
          end_reason = EXIT_LOCK;
        end else if (stop) begin
          end_run    = 1'b1;
          end_reason = EXIT_STOP;
        end else if (!any_req) begin
          settle_d = '0;
          state_d  = (RESUME_DELAY == 0) ? S_RUN : S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (!locked_s) begin
          end_run    = 1'b1;
          end_reason = EXIT_LOCK;
        end else if (stop) begin
          end_run    = 1'b1;
          end_reason = EXIT_STOP;
        end else if (any_req) begin
          state_d = S_STALL;
        end else if (settle_q == SETTLE_LAST) begin
          state_d = S_RUN;
        end else begin
          settle_d = settle_q + RCW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (end_run) begin
      state_d   = S_IDLE;
      running_d = 1'b0;
      done_d    = 1'b1;
      exit_d    = end_reason;
    end

    en_d = (state_d == S_RUN);

    // Acks only once the enable has already been low for a cycle (state was
    // STALL before this edge) and the freeze continues past it.
    ack_d = ((state_q == S_STALL) && (state_d == S_STALL)) ? stall_req : '0;
  end

  always_ff @(posedge control_clock or negedge sync_rst_n) begin
    if (!sync_rst_n) begin
      state_q   <= S_IDLE;
      budget_q  <= '0;
      count_q   <= '0;
      en_q      <= 1'b0;
      ack_q     <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      exit_q    <= EXIT_BUDGET;
      settle_q  <= '0;
    end else begin
      state_q   <= state_d;
      budget_q  <= budget_d;
      count_q   <= count_d;
      en_q      <= en_d;
      ack_q     <= ack_d;
      running_q <= running_d;
      done_q    <= done_d;
      exit_q    <= exit_d;
      settle_q  <= settle_d;
    end
  end

  assign compute_clock_en = en_q;
  assign stall_ack        = ack_q;
  assign running          = running_q;
  assign done             = done_q;
  assign exit_reason      = exit_q;
  assign cycle_count      = count_q;

endmodule

// File: tb/tb_compute_clock_gate_ctrl.sv
// Bench for compute_clock_gate_ctrl: table-driven budget/stall runs plus
// hand sequences for overlapping stalls, lock wait, lock loss and reset.
// Completed runs are scored against an expected-result queue on each done.
module tb_compute_clock_gate_ctrl;

  localparam int RD = 2;

  logic        control_clock = 1'b0;
  logic        sync_rst_n    = 1'b0;
  logic        locked        = 1'b1;
  logic        start         = 1'b0;
  logic [47:0] cycle_budget  = '0;
  logic        stop          = 1'b0;
  logic [3:0]  stall_req     = '0;
  logic [3:0]  stall_ack;
  logic        compute_clock_en;
  logic        running;
  logic        done;
  logic [1:0]  exit_reason;
  logic [47:0] cycle_count;

  compute_clock_gate_ctrl #(
    .N_REQ        (4),
    .COUNT_W      (48),
    .RESUME_DELAY (RD)
  ) dut (
    .control_clock    (control_clock),
    .sync_rst_n       (sync_rst_n),
    .locked           (locked),
    .start            (start),
    .cycle_budget     (cycle_budget),
    .stop             (stop),
    .stall_req        (stall_req),
    .stall_ack        (stall_ack),
    .compute_clock_en (compute_clock_en),
    .running          (running),
    .done             (done),
    .exit_reason      (exit_reason),
    .cycle_count      (cycle_count)
  );

  always #5 control_clock = ~control_clock;

  typedef struct {
    logic [47:0] budget;
    logic [3:0]  mask;
    int          stall_at;
    int          stall_len;
    int          exp_lat;
    logic [3:0]  exp_ack;
    bit          timing;
  } vec_t;

  typedef struct {
    logic [47:0] count;
    logic [1:0]  reason;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge control_clock);
    #1;
  endtask

  // Scoreboard: each done pulse retires the oldest expected run result.
  always @(negedge control_clock) begin
    if (sync_rst_n && done) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL done_unexpected: got done with no run expected");
      end else begin
        mon_e = exp_q.pop_front();
        check("done_cycle_count", cycle_count, mon_e.count);
        check("done_exit_reason", exit_reason, mon_e.reason);
      end
    end
  end

  task automatic run_vec(input vec_t v, input int idx);
    int t, stall_left, t_done, t_raise, t_off, t_ack_on, t_ack_off, t_resume, en_seen;
    logic [3:0] ack_or;
    bit raised;
    exp_q.push_back('{count: v.budget, reason: 2'd0});
    cycle_budget = v.budget;
    start = 1'b1;
    step();
    start = 1'b0;
    check($sformatf("v%0d_running", idx), running, 1);
    stall_left = 0; t_done = -1; t_raise = -1; t_off = -1;
    t_ack_on = -1; t_ack_off = -1; t_resume = -1; en_seen = 0;
    ack_or = '0; raised = 0;
    for (t = 0; t <= 300; t++) begin
      if (compute_clock_en) en_seen++;
      if (done && t_done < 0) t_done = t;
      ack_or = ack_or | stall_ack;
      if (t_raise >= 0) begin
        if (t_off < 0 && !compute_clock_en) t_off = t;
        if (t_ack_on < 0 && stall_ack != 0) t_ack_on = t;
        if (t_ack_on >= 0 && t_ack_off < 0 && stall_ack == 0) t_ack_off = t;
        if (t_resume < 0 && t > t_raise + 1 && compute_clock_en) t_resume = t;
      end
      if (stall_left > 0) begin
        stall_left--;
        if (stall_left == 0) stall_req = '0;
      end else if (!raised && v.stall_len > 0 && compute_clock_en && en_seen == v.stall_at) begin
        stall_req  = v.mask;
        stall_left = v.stall_len;
        raised     = 1;
        t_raise    = t;
      end
      if (t_done >= 0 && stall_left == 0) break;
      step();
    end
    stall_req = '0;
    check($sformatf("v%0d_latency", idx), t_done, v.exp_lat);
    check($sformatf("v%0d_en_cycles", idx), en_seen, v.budget);
    check($sformatf("v%0d_ack_seen", idx), ack_or, v.exp_ack);
    if (v.stall_len > 0) check($sformatf("v%0d_en_off", idx), t_off, t_raise + 1);
    if (v.timing) check($sformatf("v%0d_resume", idx), t_resume, t_raise + v.stall_len + 1 + RD);
    if (v.exp_ack != 0) begin
      check($sformatf("v%0d_ack_on", idx), t_ack_on, t_raise + 2);
      check($sformatf("v%0d_ack_off", idx), t_ack_off, t_raise + v.stall_len + 1);
    end
    repeat (2) step();
  endtask

  vec_t vecs[6];
  vec_t vec_post;

  initial begin
    vecs[0] = '{budget: 48'd10, mask: 4'b0000, stall_at: 0, stall_len: 0, exp_lat: 11, exp_ack: 4'b0000, timing: 0};
    vecs[1] = '{budget: 48'd20, mask: 4'b0100, stall_at: 5, stall_len: 6, exp_lat: 29, exp_ack: 4'b0100, timing: 1};
    vecs[2] = '{budget: 48'd1,  mask: 4'b0000, stall_at: 0, stall_len: 0, exp_lat: 2,  exp_ack: 4'b0000, timing: 0};
    vecs[3] = '{budget: 48'd8,  mask: 4'b0010, stall_at: 8, stall_len: 3, exp_lat: 9,  exp_ack: 4'b0000, timing: 0};
    vecs[4] = '{budget: 48'd5,  mask: 4'b1011, stall_at: 2, stall_len: 1, exp_lat: 9,  exp_ack: 4'b0000, timing: 1};
    vecs[5] = '{budget: 48'd6,  mask: 4'b0001, stall_at: 3, stall_len: 2, exp_lat: 11, exp_ack: 4'b0001, timing: 1};
    vec_post = '{budget: 48'd4, mask: 4'b0000, stall_at: 0, stall_len: 0, exp_lat: 5, exp_ack: 4'b0000, timing: 0};

    // Reset state.
    repeat (2) step();
    check("rst_en", compute_clock_en, 0);
    check("rst_ack", stall_ack, 0);
    check("rst_running", running, 0);
    check("rst_done", done, 0);
    check("rst_exit", exit_reason, 0);
    check("rst_count", cycle_count, 0);
    @(negedge control_clock);
    sync_rst_n = 1'b1;
    repeat (3) step();

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // Unbounded run, overlapping staggered stalls, resume, then stop.
    exp_q.push_back('{count: 48'd8, reason: 2'd1});
    cycle_budget = '0;
    start = 1'b1;
    step();                                   // t0
    start = 1'b0;
    repeat (4) step();                        // t4
    check("s3_en_run", compute_clock_en, 1);
    stall_req = 4'b0001;
    step();                                   // t5
    check("s3_en_frozen", compute_clock_en, 0);
    check("s3_ack_not_yet", stall_ack, 4'b0000);
    step();                                   // t6
    check("s3_ack0", stall_ack, 4'b0001);
    stall_req = 4'b1001;
    step();                                   // t7
    check("s3_ack03", stall_ack, 4'b1001);
    step();                                   // t8
    stall_req = 4'b1000;
    step();                                   // t9
    check("s3_ack3_only", stall_ack, 4'b1000);
    check("s3_en_still_low", compute_clock_en, 0);
    check("s3_count_frozen", cycle_count, 4);
    stall_req = 4'b0000;
    step();                                   // t10
    check("s3_ack_drop", stall_ack, 4'b0000);
    check("s3_settle0", compute_clock_en, 0);
    step();                                   // t11
    check("s3_settle1", compute_clock_en, 0);
    step();                                   // t12
    check("s3_resume", compute_clock_en, 1);
    repeat (3) step();                        // t15
    stop = 1'b1;
    step();                                   // t16
    stop = 1'b0;
    check("s3_stop_done", done, 1);
    check("s3_stop_en", compute_clock_en, 0);
    check("s3_stop_running", running, 0);
    repeat (3) step();
    check("s3_count_held", cycle_count, 8);
    check("s3_done_pulse", done, 0);

    // Start with lock absent; lock arrives 7 cycles later.
    locked = 1'b0;
    repeat (3) step();
    exp_q.push_back('{count: 48'd3, reason: 2'd0});
    cycle_budget = 48'd3;
    start = 1'b1;
    step();                                   // t0
    start = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      step();
      check($sformatf("s4_no_en_t%0d", i), compute_clock_en, 0);
      if (i == 7) locked = 1'b1;
    end
    step();                                   // t10
    check("s4_en_rise", compute_clock_en, 1);
    repeat (3) step();                        // t13
    check("s4_done", done, 1);

    // Lock loss at count 40; a mid-run start is ignored.
    repeat (2) step();
    exp_q.push_back('{count: 48'd42, reason: 2'd2});
    cycle_budget = 48'd100;
    start = 1'b1;
    step();                                   // t0
    start = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (i == 10) begin
        start = 1'b1;
        cycle_budget = 48'd5;
      end
      if (i == 11) start = 1'b0;
    end
    check("s5_en_at40", compute_clock_en, 1);
    locked = 1'b0;
    repeat (2) step();                        // t42
    check("s5_en_sync_lag", compute_clock_en, 1);
    step();                                   // t43
    check("s5_en_dropped", compute_clock_en, 0);
    check("s5_done", done, 1);
    check("s5_running", running, 0);
    step();
    check("s5_exit_held", exit_reason, 2);
    locked = 1'b1;
    repeat (3) step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("s5_idle_stop_nodone", done, 0);
    check("s5_idle_stop_exit", exit_reason, 2);
    exp_q.push_back('{count: 48'd2, reason: 2'd0});
    cycle_budget = 48'd2;
    start = 1'b1;
    stop  = 1'b1;
    step();                                   // t0
    start = 1'b0;
    stop  = 1'b0;
    check("s5_start_wins", running, 1);
    check("s5_count_cleared", cycle_count, 0);
    repeat (3) step();                        // t3
    check("s5_short_done", done, 1);
    repeat (2) step();

    // Asynchronous reset while stalled.
    cycle_budget = '0;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();
    stall_req = 4'b0010;
    repeat (2) step();
    check("s6_acked", stall_ack, 4'b0010);
    #2;
    sync_rst_n = 1'b0;
    #1;
    check("s6_rst_en", compute_clock_en, 0);
    check("s6_rst_ack", stall_ack, 0);
    check("s6_rst_running", running, 0);
    check("s6_rst_count", cycle_count, 0);
    check("s6_rst_exit", exit_reason, 0);
    stall_req = '0;
    @(negedge control_clock);
    sync_rst_n = 1'b1;
    repeat (3) step();
    run_vec(vec_post, 6);

    check("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
